// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU (ALU, controller, register file).
package cpu_pkg;
    localparam int DW      = 8;
    localparam int NREGS   = 8;
    localparam int AW      = 3;
    localparam int ACC_IDX = 0;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] raddr_t;
endpackage

// File: rtl/reg_file_flag_reg.sv
// Single-bit status flag with clear-over-enable priority; reusable for carry/zero/parity.
module flag_reg (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset)    q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (en)  q <= d;
    end
endmodule

// File: rtl/reg_file.sv
// Architectural register file with accumulator (r0) tap and shift-carry flag.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file #(
    parameter int DW    = cpu_pkg::DW,
    parameter int NREGS = cpu_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [DW-1:0] acc_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          sc_wr_en,
    input  logic          sc_in,
    input  logic          sc_clr,
    output logic          sc_out
);
    localparam logic [AW-1:0] ACC = AW'(cpu_pkg::ACC_IDX);

    logic [DW-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // A write in a reset cycle is dropped, so it must not be forwarded either.
    logic fwd;
    assign fwd      = wr_en && !reset;
    assign ra_data  = (fwd && wr_addr == ra_addr) ? wr_data : regs[ra_addr];
    assign rb_data  = (fwd && wr_addr == rb_addr) ? wr_data : regs[rb_addr];
    assign acc_data = (fwd && wr_addr == ACC)     ? wr_data : regs[ACC];
`else
    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign acc_data = regs[ACC];
`endif

    flag_reg u_sc (
        .clk   (clk),
        .reset (reset),
        .clr   (sc_clr),
        .en    (sc_wr_en),
        .d     (sc_in),
        .q     (sc_out)
    );
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus randomized model comparison.
module tb_reg_file;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ra_addr, rb_addr, wr_addr;
    logic [7:0] ra_data, rb_data, acc_data, wr_data;
    logic       wr_en, sc_wr_en, sc_in, sc_clr, sc_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .acc_data (acc_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sc_wr_en (sc_wr_en),
        .sc_in    (sc_in),
        .sc_clr   (sc_clr),
        .sc_out   (sc_out)
    );

    typedef struct {
        logic       chk;
        logic       rst;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       sce;
        logic       sci;
        logic       scc;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] era;
        logic [7:0] erb;
        logic [7:0] eacc;
        logic       esc;
    } vec_t;

    vec_t vecs [17];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic sce, input logic sci, input logic scc,
                         input logic [2:0] ra, input logic [2:0] rb);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        sc_wr_en = sce; sc_in = sci; sc_clr = scc; ra_addr = ra; rb_addr = rb;
    endtask

    // Reference model state
    logic [7:0] mem [8];
    logic       msc;

    initial begin
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

        //          chk  rst  we   wa    wd     sce  sci  scc  ra    rb    era                  erb                  eacc                 esc
        vecs[0]  = '{1'b0,1'b1,1'b1,3'd3,8'hAA,1'b1,1'b1,1'b0,3'd3,3'd3,8'h00,               8'h00,               8'h00,               1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b1,3'd3,8'hAA,1'b1,1'b1,1'b0,3'd3,3'd3,8'h00,               8'h00,               8'h00,               1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd3,3'd5,8'h00,               8'h00,               8'h00,               1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b1,3'd3,8'h5C,1'b0,1'b0,1'b0,3'd3,3'd3,BYP ? 8'h5C : 8'h00, BYP ? 8'h5C : 8'h00, 8'h00,               1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd3,3'd3,8'h5C,               8'h5C,               8'h00,               1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b1,3'd0,8'h81,1'b0,1'b0,1'b0,3'd0,3'd3,BYP ? 8'h81 : 8'h00, 8'h5C,               BYP ? 8'h81 : 8'h00, 1'b0};
        vecs[6]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd0,3'd3,8'h81,               8'h5C,               8'h81,               1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b1,3'd2,8'h11,1'b0,1'b0,1'b0,3'd2,3'd2,BYP ? 8'h11 : 8'h00, BYP ? 8'h11 : 8'h00, 8'h81,               1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,3'd2,8'h22,1'b0,1'b0,1'b0,3'd2,3'd3,BYP ? 8'h22 : 8'h11, 8'h5C,               8'h81,               1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd2,3'd2,8'h22,               8'h22,               8'h81,               1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b1,1'b1,1'b0,3'd2,3'd2,8'h22,               8'h22,               8'h81,               1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b1,1'b1,1'b1,3'd2,3'd2,8'h22,               8'h22,               8'h81,               1'b1};
        vecs[12] = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd2,3'd2,8'h22,               8'h22,               8'h81,               1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd2,3'd2,8'h22,               8'h22,               8'h81,               1'b0};
        vecs[14] = '{1'b1,1'b0,1'b1,3'd5,8'hFF,1'b1,1'b1,1'b0,3'd5,3'd0,BYP ? 8'hFF : 8'h00, 8'h81,               8'h81,               1'b0};
        vecs[15] = '{1'b1,1'b1,1'b1,3'd5,8'h01,1'b0,1'b0,1'b0,3'd4,3'd0,8'h00,               8'h81,               8'h81,               1'b1};
        vecs[16] = '{1'b1,1'b0,1'b0,3'd0,8'h00,1'b0,1'b0,1'b0,3'd5,3'd0,8'h00,               8'h00,               8'h00,               1'b0};

        @(posedge clk); #1;

        // Directed table: outputs observed in the cycle the inputs are applied, before the edge.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].sce, vecs[i].sci, vecs[i].scc, vecs[i].ra, vecs[i].rb);
            #1;
            if (vecs[i].chk) begin
                check8($sformatf("vec%0d.ra", i),  ra_data,  vecs[i].era);
                check8($sformatf("vec%0d.rb", i),  rb_data,  vecs[i].erb);
                check8($sformatf("vec%0d.acc", i), acc_data, vecs[i].eacc);
                check8($sformatf("vec%0d.sc", i),  {7'd0, sc_out}, {7'd0, vecs[i].esc});
            end
            @(posedge clk); #1;
        end

        // Randomized phase against a behavioural model, starting from a known reset.
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        msc = 1'b0;

        for (int n = 0; n < 400; n++) begin
            logic       r, we, sce, sci, scc;
            logic [2:0] wa, ra, rb;
            logic [7:0] wd, xra, xrb, xacc;
            r   = ($urandom_range(0, 31) == 0);
            we  = $urandom_range(0, 1) != 0;
            wa  = 3'($urandom_range(0, 7));
            wd  = 8'($urandom);
            sce = $urandom_range(0, 1) != 0;
            sci = $urandom_range(0, 1) != 0;
            scc = ($urandom_range(0, 3) == 0);
            ra  = 3'($urandom_range(0, 7));
            rb  = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom_range(0, 7));
            drive(r, we, wa, wd, sce, sci, scc, ra, rb);
            #1;
            xra  = (BYP && we && !r && wa == ra)    ? wd : mem[ra];
            xrb  = (BYP && we && !r && wa == rb)    ? wd : mem[rb];
            xacc = (BYP && we && !r && wa == 3'd0)  ? wd : mem[0];
            check8("rnd.ra",  ra_data,  xra);
            check8("rnd.rb",  rb_data,  xrb);
            check8("rnd.acc", acc_data, xacc);
            check8("rnd.sc",  {7'd0, sc_out}, {7'd0, msc});
            @(posedge clk); #1;
            if (r) begin
                for (int k = 0; k < 8; k++) mem[k] = 8'h00;
                msc = 1'b0;
            end else begin
                if (we) mem[wa] = wd;
                if (scc)      msc = 1'b0;
                else if (sce) msc = sci;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
